// File: rtl/branch_resolve_tracker.sv
// ---------------------------------------------------------------------------
// branch_resolve_tracker
//
// In-order tracker for predicted branches. Fetch pushes each predicted
// branch {pc, pred, target}. EX resolves the oldest one. The tracker then
// trains the direction predictor, flags mispredictions with a redirect PC,
// and squashes younger wrong-path entries.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   push_valid/pc/pred/target   fetch-side record of a predicted branch
//   push_ready        count < DEPTH
//   res_valid/taken/target      EX resolution of the oldest branch
//   flush             external pipeline flush, highest priority
//   we_bp, update_res, write_pc predictor training port (1-cycle strobe)
//   mispredict, redirect_pc     redirect strobe and correct next fetch PC
//   count             entries in flight
//   err               push while full, or resolve while empty (1-cycle)
// ---------------------------------------------------------------------------
module branch_resolve_tracker #(
   parameter  int ADDR_WIDTH = 26,
   parameter  int DEPTH      = 4,
   localparam int PTR_WIDTH  = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_valid,
   input  logic [ADDR_WIDTH-1:0] push_pc,
   input  logic                  push_pred,
   input  logic [ADDR_WIDTH-1:0] push_target,
   output logic                  push_ready,
   input  logic                  res_valid,
   input  logic                  res_taken,
   input  logic [ADDR_WIDTH-1:0] res_target,
   input  logic                  flush,
   output logic                  we_bp,
   output logic                  update_res,
   output logic [ADDR_WIDTH-1:0] write_pc,
   output logic                  mispredict,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [PTR_WIDTH:0]    count,
   output logic                  err
);

   localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] pc_mem  [DEPTH];
   logic                  pred_mem[DEPTH];
   logic [ADDR_WIDTH-1:0] tgt_mem [DEPTH];

   logic [PTR_WIDTH-1:0]  head, tail;
   logic [PTR_WIDTH:0]    count_p0;

   logic                  we_bp_p1, update_res_p1, mispredict_p1, err_p1;
   logic [ADDR_WIDTH-1:0] write_pc_p1, redirect_pc_p1;

   logic [ADDR_WIDTH-1:0] head_pc, head_tgt, redirect_nxt;
   logic                  head_pred;
   logic                  full, res_fire, mis, squash, push_ok, err_nxt;
   logic [PTR_WIDTH:0]    count_nxt;

   // ---- stage p0: FIFO head lookup and event decode ----
   always_comb begin
      head_pc      = pc_mem[head];
      head_pred    = pred_mem[head];
      head_tgt     = tgt_mem[head];
      full         = (count_p0 == FULL_CNT);
      res_fire     = res_valid && (count_p0 != '0) && !flush;
      mis          = (res_taken != head_pred) ||
                     (res_taken && head_pred && (res_target != head_tgt));
      squash       = res_fire && mis;
      // A push alongside a mispredicting resolve is wrong-path: dropped, no err.
      push_ok      = push_valid && !full && !flush && !squash;
      err_nxt      = !flush && ((push_valid && full && !squash) ||
                                (res_valid && (count_p0 == '0)));
      redirect_nxt = res_taken ? res_target : head_pc + 1'b1;
      count_nxt    = count_p0 + {{PTR_WIDTH{1'b0}}, push_ok}
                              - {{PTR_WIDTH{1'b0}}, res_fire};
   end

   // Entry storage carries no reset; validity is tracked by head/tail/count.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         pc_mem[tail]   <= push_pc;
         pred_mem[tail] <= push_pred;
         tgt_mem[tail]  <= push_target;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head     <= '0;
         tail     <= '0;
         count_p0 <= '0;
      end else if (flush) begin
         head     <= '0;
         tail     <= '0;
         count_p0 <= '0;
      end else if (squash) begin
         head     <= head + 1'b1;
         tail     <= head + 1'b1;
         count_p0 <= '0;
      end else begin
         if (res_fire) head <= head + 1'b1;
         if (push_ok)  tail <= tail + 1'b1;
         count_p0 <= count_nxt;
      end
   end

   // ---- stage p1: registered predictor-update and redirect outputs ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_bp_p1       <= 1'b0;
         update_res_p1  <= 1'b0;
         write_pc_p1    <= '0;
         mispredict_p1  <= 1'b0;
         redirect_pc_p1 <= '0;
         err_p1         <= 1'b0;
      end else begin
         we_bp_p1      <= res_fire;
         mispredict_p1 <= squash;
         err_p1        <= err_nxt;
         if (res_fire) begin
            update_res_p1 <= res_taken;
            write_pc_p1   <= head_pc;
         end
         if (squash) redirect_pc_p1 <= redirect_nxt;
      end
   end

   assign push_ready  = (count_p0 < FULL_CNT);
   assign count       = count_p0;
   assign we_bp       = we_bp_p1;
   assign update_res  = update_res_p1;
   assign write_pc    = write_pc_p1;
   assign mispredict  = mispredict_p1;
   assign redirect_pc = redirect_pc_p1;
   assign err         = err_p1;

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_tracker
//
// Directed vector table for the documented scenarios, hand-written async
// reset sequence, then randomized traffic against a queue-based model.
// ---------------------------------------------------------------------------
module tb_branch_resolve_tracker;

   localparam int AW    = 26;
   localparam int DEPTH = 4;

   logic          clk, rst_n;
   logic          push_valid, push_pred, push_ready;
   logic [AW-1:0] push_pc, push_target;
   logic          res_valid, res_taken, flush;
   logic [AW-1:0] res_target;
   logic          we_bp, update_res, mispredict, err;
   logic [AW-1:0] write_pc, redirect_pc;
   logic [2:0]    count;

   branch_resolve_tracker #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .push_valid(push_valid), .push_pc(push_pc), .push_pred(push_pred),
      .push_target(push_target), .push_ready(push_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .flush(flush),
      .we_bp(we_bp), .update_res(update_res), .write_pc(write_pc),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .count(count), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          pv;
      logic [AW-1:0] ppc;
      logic          pp;
      logic [AW-1:0] pt;
      logic          rv;
      logic          rt;
      logic [AW-1:0] rtg;
      logic          fl;
      logic          e_we;
      logic          e_upd;
      logic [AW-1:0] e_wpc;
      logic          e_mis;
      logic [AW-1:0] e_rpc;
      logic          e_err;
      logic [2:0]    e_cnt;
   } vec_t;

   typedef struct {
      logic [AW-1:0] pc;
      logic          pred;
      logic [AW-1:0] tgt;
   } ent_t;

   vec_t vecs[$];
   ent_t q[$];
   logic          m_we, m_upd, m_mis, m_err;
   logic [AW-1:0] m_wpc, m_rpc;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic pv, input logic [AW-1:0] ppc, input logic pp,
                      input logic [AW-1:0] pt, input logic rv, input logic rt,
                      input logic [AW-1:0] rtg, input logic fl,
                      input logic we, input logic upd, input logic [AW-1:0] wpc,
                      input logic mis, input logic [AW-1:0] rpc,
                      input logic er, input logic [2:0] cnt);
      vec_t v;
      v.pv = pv; v.ppc = ppc; v.pp = pp; v.pt = pt;
      v.rv = rv; v.rt = rt; v.rtg = rtg; v.fl = fl;
      v.e_we = we; v.e_upd = upd; v.e_wpc = wpc; v.e_mis = mis;
      v.e_rpc = rpc; v.e_err = er; v.e_cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      push_valid  = v.pv;  push_pc   = v.ppc; push_pred  = v.pp; push_target = v.pt;
      res_valid   = v.rv;  res_taken = v.rt;  res_target = v.rtg;
      flush       = v.fl;
   endtask

   task automatic idle_inputs();
      push_valid = 0; push_pc = '0; push_pred = 0; push_target = '0;
      res_valid = 0; res_taken = 0; res_target = '0; flush = 0;
   endtask

   // Behavioural reference: queue of in-flight branches, one call per cycle.
   task automatic model_step(input vec_t v);
      ent_t e;
      bit   was_full, res, m;
      if (v.fl) begin
         q.delete();
         m_we = 0; m_mis = 0; m_err = 0;
      end else begin
         was_full = (q.size() == DEPTH);
         res      = v.rv && (q.size() > 0);
         m        = 0;
         m_we     = res;
         m_mis    = 0;
         m_err    = v.rv && (q.size() == 0);
         if (res) begin
            e     = q[0];
            m_upd = v.rt;
            m_wpc = e.pc;
            m = (v.rt != e.pred) || (v.rt && e.pred && (v.rtg != e.tgt));
            if (m) begin
               m_mis = 1;
               m_rpc = v.rt ? v.rtg : e.pc + 26'd1;
            end
         end
         if (m) q.delete();
         else begin
            if (res) void'(q.pop_front());
            if (v.pv) begin
               if (was_full) m_err = 1;
               else begin
                  e.pc = v.ppc; e.pred = v.pp; e.tgt = v.pt;
                  q.push_back(e);
               end
            end
         end
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_we = 0; m_upd = 0; m_mis = 0; m_err = 0; m_wpc = '0; m_rpc = '0;
   endtask

   initial begin
      vec_t v;
      idle_inputs();
      rst_n = 0;
      model_reset();

      // ---------------- reset state ----------------
      #3;
      chk("rst_count", count, 0);
      chk("rst_we_bp", we_bp, 0);
      chk("rst_mispredict", mispredict, 0);
      chk("rst_err", err, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      chk("rst_push_ready", push_ready, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;

      // ---------------- directed vector table ----------------
      add(1,'h10,0,0, 0,0,0, 0, 0,0,0, 0,0, 0,1);
      add(0,0,0,0, 1,1,'h40, 0, 1,1,'h10, 1,'h40, 0,0);
      for (int i = 1; i <= 4; i++) add(1,AW'(i),1,'h20, 0,0,0, 0, 0,0,0, 0,0, 0,3'(i));
      add(1,5,1,'h20, 0,0,0, 0, 0,0,0, 0,0, 1,4);
      for (int i = 1; i <= 4; i++) add(0,0,0,0, 1,1,'h20, 0, 1,1,AW'(i), 0,0, 0,3'(4-i));
      add(1,'h3FFFFFF,1,'h100, 0,0,0, 0, 0,0,0, 0,0, 0,1);
      add(0,0,0,0, 1,0,0, 0, 1,0,'h3FFFFFF, 1,'h0, 0,0);
      add(1,'h8,1,'h20, 0,0,0, 0, 0,0,0, 0,0, 0,1);
      add(0,0,0,0, 1,1,'h24, 0, 1,1,'h8, 1,'h24, 0,0);
      for (int i = 0; i < 3; i++) add(1,AW'('h30+i),0,0, 0,0,0, 0, 0,0,0, 0,0, 0,3'(i+1));
      add(1,'h33,0,0, 1,1,'h50, 0, 1,1,'h30, 1,'h50, 0,0);
      add(0,0,0,0, 1,0,0, 0, 0,0,0, 0,0, 1,0);
      add(0,0,0,0, 0,0,0, 0, 0,0,0, 0,0, 0,0);
      for (int i = 0; i < 3; i++) add(1,AW'('h40+i),0,0, 0,0,0, 0, 0,0,0, 0,0, 0,3'(i+1));
      add(1,'h50,0,0, 1,0,0, 1, 0,0,0, 0,0, 0,0);
      add(1,'h60,0,0, 0,0,0, 0, 0,0,0, 0,0, 0,1);
      add(1,'h61,1,'h70, 1,0,0, 0, 1,0,'h60, 0,0, 0,1);
      add(0,0,0,0, 1,1,'h70, 0, 1,1,'h61, 0,0, 0,0);
      for (int i = 0; i < 4; i++) add(1,AW'('h80+i),0,0, 0,0,0, 0, 0,0,0, 0,0, 0,3'(i+1));
      add(1,'h84,0,0, 1,0,0, 0, 1,0,'h80, 0,0, 1,3);
      for (int i = 0; i < 3; i++) add(0,0,0,0, 1,0,0, 0, 1,0,AW'('h81+i), 0,0, 0,3'(2-i));

      foreach (vecs[k]) begin
         @(negedge clk);
         drive(vecs[k]);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_we_bp", k), we_bp, vecs[k].e_we);
         chk($sformatf("v%0d_mispredict", k), mispredict, vecs[k].e_mis);
         chk($sformatf("v%0d_err", k), err, vecs[k].e_err);
         chk($sformatf("v%0d_count", k), count, vecs[k].e_cnt);
         chk($sformatf("v%0d_push_ready", k), push_ready, vecs[k].e_cnt < DEPTH);
         if (vecs[k].e_we) begin
            chk($sformatf("v%0d_update_res", k), update_res, vecs[k].e_upd);
            chk($sformatf("v%0d_write_pc", k), write_pc, vecs[k].e_wpc);
         end
         if (vecs[k].e_mis) chk($sformatf("v%0d_redirect_pc", k), redirect_pc, vecs[k].e_rpc);
      end

      // ---------------- async reset mid-cycle with count=3 ----------------
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         idle_inputs();
         push_valid = 1; push_pc = AW'('h90 + i);
      end
      @(negedge clk);
      idle_inputs();
      res_valid = 1;
      @(posedge clk);
      #1;
      chk("ar_pre_count", count, 3);
      chk("ar_pre_we_bp", we_bp, 1);
      chk("ar_pre_write_pc", write_pc, 'h90);
      @(negedge clk);
      idle_inputs();
      #2 rst_n = 0;
      #1;
      chk("ar_count", count, 0);
      chk("ar_we_bp", we_bp, 0);
      chk("ar_write_pc", write_pc, 0);
      chk("ar_redirect_pc", redirect_pc, 0);
      chk("ar_update_res", update_res, 0);
      chk("ar_push_ready", push_ready, 1);
      @(negedge clk);
      rst_n = 1;
      model_reset();

      // ---------------- randomized traffic vs queue model ----------------
      for (int i = 0; i < 600; i++) begin
         v = '{default: '0};
         v.pv  = ($urandom_range(0, 99) < 55);
         v.ppc = AW'($urandom);
         v.pp  = 1'($urandom_range(0, 1));
         v.pt  = ($urandom_range(0, 1) == 1) ? AW'('h100) : AW'($urandom);
         v.rv  = ($urandom_range(0, 99) < 45);
         v.fl  = ($urandom_range(0, 99) < 3);
         if (q.size() > 0 && $urandom_range(0, 3) != 0) v.rt = q[0].pred;
         else v.rt = 1'($urandom_range(0, 1));
         if (q.size() > 0 && $urandom_range(0, 4) != 0) v.rtg = q[0].tgt;
         else v.rtg = AW'($urandom);
         @(negedge clk);
         drive(v);
         model_step(v);
         @(posedge clk);
         #1;
         chk("rnd_we_bp", we_bp, m_we);
         chk("rnd_mispredict", mispredict, m_mis);
         chk("rnd_err", err, m_err);
         chk("rnd_count", count, q.size());
         chk("rnd_push_ready", push_ready, q.size() < DEPTH);
         chk("rnd_redirect_pc", redirect_pc, m_rpc);
         if (m_we) begin
            chk("rnd_update_res", update_res, m_upd);
            chk("rnd_write_pc", write_pc, m_wpc);
         end
      end

      @(negedge clk);
      idle_inputs();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
